// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with pending-write
// scoreboard and clear sweeper; optional bypass via REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              busy,
  input  logic              D_En,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] S_Addr,
  input  logic [ADDR_W-1:0] T_Addr,
  output logic [DATA_W-1:0] S,
  output logic [DATA_W-1:0] T,
  output logic              S_Pend,
  output logic              T_Pend,
  input  logic              rsv_En,
  input  logic [ADDR_W-1:0] rsv_Addr,
  output logic              rsv_Ok
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              busy_q;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_nxt;

  logic d_zero;
  logic r_zero;
  logic s_zero;
  logic t_zero;
  logic wr_acc;
  logic rsv_set;
  logic s_byp;
  logic t_byp;

  assign busy = busy_q;

  assign d_zero = ZR && (D_Addr == '0);
  assign r_zero = ZR && (rsv_Addr == '0);
  assign s_zero = ZR && (S_Addr == '0);
  assign t_zero = ZR && (T_Addr == '0);

  assign wr_acc  = D_En & ~busy_q & ~d_zero;
  assign rsv_Ok  = rsv_En & ~busy_q & ~pend[rsv_Addr];
  assign rsv_set = rsv_Ok & ~r_zero;

`ifdef REGFILE_BYPASS_EN
  assign s_byp = wr_acc && (D_Addr == S_Addr);
  assign t_byp = wr_acc && (D_Addr == T_Addr);
`else
  assign s_byp = 1'b0;
  assign t_byp = 1'b0;
`endif

  // Clear sequencer: sweep index over the array, busy while sweeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SWEEP;
      idx    <= '0;
      busy_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state  <= SWEEP;
            idx    <= '0;
            busy_q <= 1'b1;
          end
        end
        SWEEP: begin
          if (idx == LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state  <= SWEEP;
          idx    <= '0;
          busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage: sweep zeroing has priority; writeback only when idle.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      regs[idx] <= '0;
    end else if (wr_acc) begin
      regs[D_Addr] <= D;
    end
  end

  // Next scoreboard: clear-all on sweep start, else release then reserve.
  always_comb begin
    pend_nxt = pend;
    if (busy_q) begin
      pend_nxt = '0;
    end else if (clr_start) begin
      pend_nxt = '0;
    end else begin
      if (wr_acc) begin
        pend_nxt[D_Addr] = 1'b0;
      end
      if (rsv_set) begin
        pend_nxt[rsv_Addr] = 1'b1;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Read ports: masked while busy, optional same-cycle bypass.
  always_comb begin
    S      = '0;
    T      = '0;
    S_Pend = 1'b0;
    T_Pend = 1'b0;
    if (!busy_q) begin
      if (!s_zero) begin
        S = regs[S_Addr];
      end
      if (!t_zero) begin
        T = regs[T_Addr];
      end
      S_Pend = pend[S_Addr];
      T_Pend = pend[T_Addr];
      if (s_byp) begin
        S      = D;
        S_Pend = 1'b0;
      end
      if (t_byp) begin
        T      = D;
        T_Pend = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random stimulus checked against a
// behavioural register-file/scoreboard model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_start;
  logic        busy;
  logic        D_En;
  logic [4:0]  D_Addr;
  logic [31:0] D;
  logic [4:0]  S_Addr;
  logic [4:0]  T_Addr;
  logic [31:0] S;
  logic [31:0] T;
  logic        S_Pend;
  logic        T_Pend;
  logic        rsv_En;
  logic [4:0]  rsv_Addr;
  logic        rsv_Ok;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];
  int          sweep_left;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .clr_start (clr_start),
    .busy      (busy),
    .D_En      (D_En),
    .D_Addr    (D_Addr),
    .D         (D),
    .S_Addr    (S_Addr),
    .T_Addr    (T_Addr),
    .S         (S),
    .T         (T),
    .S_Pend    (S_Pend),
    .T_Pend    (T_Pend),
    .rsv_En    (rsv_En),
    .rsv_Addr  (rsv_Addr),
    .rsv_Ok    (rsv_Ok)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit byp(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    return D_En && (D_Addr == a) && (a != 0) && (sweep_left == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (sweep_left != 0) return 32'h0;
    if (byp(a)) return D;
    if (a == 0) return 32'h0;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] exp_pd(input logic [4:0] a);
    if (sweep_left != 0) return 32'h0;
    if (byp(a)) return 32'h0;
    return 32'(m_pend[a]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    clr_start = 1'b0;
    D_En      = 1'b0;
    D_Addr    = '0;
    D         = '0;
    S_Addr    = '0;
    T_Addr    = '0;
    rsv_En    = 1'b0;
    rsv_Addr  = '0;
  endtask

  // One clock: check outputs against the model, then apply the edge.
  task automatic cyc();
    bit ok;
    #1;
    ok = rsv_En && (sweep_left == 0) && !m_pend[rsv_Addr];
    chk("busy", 32'(busy), 32'(sweep_left != 0));
    chk("S", S, exp_rd(S_Addr));
    chk("T", T, exp_rd(T_Addr));
    chk("S_Pend", 32'(S_Pend), exp_pd(S_Addr));
    chk("T_Pend", 32'(T_Pend), exp_pd(T_Addr));
    chk("rsv_Ok", 32'(rsv_Ok), 32'(ok));
    @(posedge clk);
    if (reset) begin
      if (sweep_left != 0) begin
        sweep_left--;
      end else if (clr_start) begin
        model_clear();
        sweep_left = 32;
      end else begin
        if (D_En && D_Addr != 0) begin
          m_reg[D_Addr]  = D;
          m_pend[D_Addr] = 1'b0;
        end
        if (ok && rsv_Addr != 0) m_pend[rsv_Addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_clear();
    sweep_left = 32;
    repeat (n) cyc();
    reset = 1'b1;
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n), 32'd32);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_clear();
    sweep_left = 32;
    @(negedge clk);
    do_reset(2);
    wait_sweep("rst_len0");

    // Pre-write reg 31, then reset and check it is swept.
    D_En = 1'b1; D_Addr = 5'd31; D = 32'hCAFEF00D;
    cyc();
    idle();
    S_Addr = 5'd31;
    #1 chk("w31", S, 32'hCAFEF00D);
    cyc();
    do_reset(3);
    wait_sweep("rst_len");
    for (int i = 0; i < 32; i++) begin
      S_Addr = 5'(i);
      T_Addr = 5'(31 - i);
      #1 chk("clr_rd", S, 32'h0);
      cyc();
    end

    // Basic write/read and the hardwired zero register.
    idle();
    D_En = 1'b1; D_Addr = 5'd5; D = 32'hDEADBEEF;
    cyc();
    idle();
    S_Addr = 5'd5;
    #1 chk("w5", S, 32'hDEADBEEF);
    cyc();
    D_En = 1'b1; D_Addr = 5'd0; D = 32'hFFFFFFFF;
    cyc();
    idle();
    T_Addr = 5'd0;
    #1 chk("r0", T, 32'h0);
    cyc();

    // Reservation lifecycle on reg 7.
    rsv_En = 1'b1; rsv_Addr = 5'd7;
    #1 chk("rsv7_ok", 32'(rsv_Ok), 32'd1);
    cyc();
    S_Addr = 5'd7;
    #1 chk("rsv7_again", 32'(rsv_Ok), 32'd0);
    chk("pend7", 32'(S_Pend), 32'd1);
    cyc();
    idle();
    D_En = 1'b1; D_Addr = 5'd7; D = 32'h12345678;
    cyc();
    idle();
    S_Addr = 5'd7;
    #1 chk("pend7_clr", 32'(S_Pend), 32'd0);
    chk("w7", S, 32'h12345678);
    cyc();

    // Collision with pending bit set: write wins, reservation refused.
    rsv_En = 1'b1; rsv_Addr = 5'd9;
    cyc();
    D_En = 1'b1; D_Addr = 5'd9; D = 32'h00000055;
    #1 chk("rsv9_coll", 32'(rsv_Ok), 32'd0);
    cyc();
    idle();
    S_Addr = 5'd9;
    #1 chk("pend9", 32'(S_Pend), 32'd0);
    cyc();

    // Collision with clear pending bit: reservation wins.
    D_En = 1'b1; D_Addr = 5'd10; D = 32'h0000AAAA;
    rsv_En = 1'b1; rsv_Addr = 5'd10;
    #1 chk("rsv10_ok", 32'(rsv_Ok), 32'd1);
    cyc();
    idle();
    T_Addr = 5'd10;
    #1 chk("pend10", 32'(T_Pend), 32'd1);
    cyc();

    // Same-cycle read of a register being written.
    D_En = 1'b1; D_Addr = 5'd3; D = 32'hA5A5A5A5; S_Addr = 5'd3;
`ifdef REGFILE_BYPASS_EN
    #1 chk("byp3", S, 32'hA5A5A5A5);
`else
    #1 chk("byp3", S, 32'h0);
`endif
    cyc();
    D_En = 1'b0;
    #1 chk("w3", S, 32'hA5A5A5A5);
    cyc();

    // Clear command; writes and reservations ignored while busy.
    idle();
    clr_start = 1'b1;
    cyc();
    idle();
    D_En = 1'b1; D_Addr = 5'd12; D = 32'h11112222;
    rsv_En = 1'b1; rsv_Addr = 5'd13;
    wait_sweep("clr_len");
    idle();
    for (int i = 0; i < 32; i++) begin
      S_Addr = 5'(i);
      T_Addr = 5'(i);
      #1 chk("clr_pend", 32'(S_Pend), 32'd0);
      cyc();
    end

    // Reset in the middle of a clear sweep.
    clr_start = 1'b1;
    cyc();
    idle();
    repeat (10) cyc();
    do_reset(2);
    wait_sweep("mid_rst_len");

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 400 == 0) do_reset(1 + int'($urandom % 3));
      clr_start = ($urandom % 80 == 0);
      D_En      = $urandom % 2;
      D         = $urandom;
      rsv_En    = $urandom % 2;
      if ($urandom % 4 == 0) begin
        D_Addr   = 5'($urandom);
        rsv_Addr = 5'($urandom);
        S_Addr   = 5'($urandom);
        T_Addr   = 5'($urandom);
      end else begin
        D_Addr   = 5'($urandom_range(0, 7));
        rsv_Addr = 5'($urandom_range(0, 7));
        S_Addr   = 5'($urandom_range(0, 7));
        T_Addr   = 5'($urandom_range(0, 7));
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
